cache_mem_arbiter: RTL and testbench

//  Shares one memory-controller port between two burst requesters: port 0 (icache

---
 rtl/cache_mem_arbiter_if.sv | 53 +++++
 rtl/cache_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache fill ports, the arbiter and the memory controller.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface cache_mem_arbiter_if #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32
);
  logic [ADDRBITS-1:0] req0_addr;
  logic [DATABITS-1:0] req0_in;
  logic                req0_rdreq;
  logic                req0_wrreq;
  logic                req0_grant;
  logic [DATABITS-1:0] req0_out;
  logic                req0_out_valid;
  logic                req0_in_ack;
  logic                req0_err;

  logic [ADDRBITS-1:0] req1_addr;
  logic [DATABITS-1:0] req1_in;
  logic                req1_rdreq;
  logic                req1_wrreq;
  logic                req1_grant;
  logic [DATABITS-1:0] req1_out;
  logic                req1_out_valid;
  logic                req1_in_ack;
  logic                req1_err;

  logic [ADDRBITS-1:0] mem_addr;
  logic [DATABITS-1:0] mem_in;
  logic                mem_rdreq;
  logic                mem_wrreq;
  logic [DATABITS-1:0] mem_out;
  logic                mem_out_valid;
  logic                mem_in_ack;
  logic [15:0]         mem_burstlen;

  modport master (
    input  req0_addr, req0_in, req0_rdreq, req0_wrreq,
    input  req1_addr, req1_in, req1_rdreq, req1_wrreq,
    input  mem_out, mem_out_valid, mem_in_ack, mem_burstlen,
    output req0_grant, req0_out, req0_out_valid, req0_in_ack, req0_err,
    output req1_grant, req1_out, req1_out_valid, req1_in_ack, req1_err,
    output mem_addr, mem_in, mem_rdreq, mem_wrreq
  );

  modport slave (
    output req0_addr, req0_in, req0_rdreq, req0_wrreq,
    output req1_addr, req1_in, req1_rdreq, req1_wrreq,
    output mem_out, mem_out_valid, mem_in_ack, mem_burstlen,
    input  req0_grant, req0_out, req0_out_valid, req0_in_ack, req0_err,
    input  req1_grant, req1_out, req1_out_valid, req1_in_ack, req1_err,
    input  mem_addr, mem_in, mem_rdreq, mem_wrreq
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Two-port round-robin burst arbiter in front of a single memory-controller port,
// with a per-burst beat counter and a stall watchdog.
module cache_mem_arbiter #(
  parameter int DATABITS    = 32,
  parameter int ADDRBITS    = 32,
  parameter int TIMEOUTBITS = 10
) (
  input logic                 clk,
  input logic                 reset,
  cache_mem_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, GRANT, READ, WRITE, RELEASE} state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 wr_q, wr_d;
  logic                 rr_q, rr_d;
  logic [ADDRBITS-1:0]  addr_q, addr_d;
  logic [15:0]          blen_q, blen_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [TIMEOUTBITS-1:0] wd_q, wd_d;
  logic [DATABITS-1:0]  out0_q, out1_q;
  logic                 ov0_q, ov1_q;

  logic want0, want1, beat, err, active, rd_beat;

  assign want0   = bus.req0_rdreq | bus.req0_wrreq;
  assign want1   = bus.req1_rdreq | bus.req1_wrreq;
  assign active  = (state_q != IDLE);
  assign rd_beat = (state_q == READ) & bus.mem_out_valid;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    blen_d  = blen_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    beat    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (want0 | want1) begin
          // Contention resolved by the pointer; a lone requester always wins.
          owner_d = want1 & (~want0 | rr_q);
          addr_d  = owner_d ? bus.req1_addr : bus.req0_addr;
          wr_d    = owner_d ? bus.req1_wrreq : bus.req0_wrreq;
          blen_d  = (bus.mem_burstlen == 16'd0) ? 16'd1 : bus.mem_burstlen;
          state_d = GRANT;
        end
      end
      GRANT: state_d = wr_q ? WRITE : READ;
      READ, WRITE: begin
        beat = (state_q == READ) ? bus.mem_out_valid : bus.mem_in_ack;
        if (beat) begin
          cnt_d = cnt_q + 16'd1;
          wd_d  = '0;
          if (cnt_q + 16'd1 == blen_q) state_d = RELEASE;
        end else if (wd_q == '1) begin
          err     = 1'b1;
          state_d = RELEASE;
        end else begin
          wd_d = wd_q + TIMEOUTBITS'(1);
        end
      end
      RELEASE: begin
        cnt_d   = '0;
        wd_d    = '0;
        rr_d    = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
      blen_q  <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      ov0_q   <= 1'b0;
      ov1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      blen_q  <= blen_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      ov0_q   <= rd_beat & ~owner_q;
      ov1_q   <= rd_beat & owner_q;
      out0_q  <= (rd_beat & ~owner_q) ? bus.mem_out : '0;
      out1_q  <= (rd_beat & owner_q) ? bus.mem_out : '0;
    end
  end

  assign bus.req0_grant     = active & ~owner_q;
  assign bus.req1_grant     = active & owner_q;
  assign bus.mem_addr       = active ? addr_q : '0;
  assign bus.mem_rdreq      = (state_q == GRANT) & ~wr_q;
  assign bus.mem_wrreq      = (state_q == GRANT) & wr_q;
  assign bus.mem_in         = active ? (owner_q ? bus.req1_in : bus.req0_in) : '0;
  assign bus.req0_in_ack    = (state_q == WRITE) & bus.mem_in_ack & ~owner_q;
  assign bus.req1_in_ack    = (state_q == WRITE) & bus.mem_in_ack & owner_q;
  assign bus.req0_err       = err & ~owner_q;
  assign bus.req1_err       = err & owner_q;
  assign bus.req0_out       = out0_q;
  assign bus.req1_out       = out1_q;
  assign bus.req0_out_valid = ov0_q;
  assign bus.req1_out_valid = ov1_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed cycle-by-cycle vectors for the burst arbiter plus a hand-written watchdog run.
module tb_cache_mem_arbiter;
  localparam logic [31:0] A0  = 32'h0000_1000;
  localparam logic [31:0] A1  = 32'h0000_2000;
  localparam logic [31:0] IN0 = 32'h0000_AAAA;
  localparam logic [31:0] Z   = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.DATABITS(32), .ADDRBITS(32)) bus ();

  cache_mem_arbiter #(.DATABITS(32), .ADDRBITS(32), .TIMEOUTBITS(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        rst, rd0, wr0, rd1, wr1, mov;
    logic [31:0] mout;
    logic        mack;
    logic [15:0] blen;
    logic [31:0] in1;
    logic [1:0]  g;
    logic        mrd, mwr;
    logic [31:0] maddr;
    logic [1:0]  ov;
    logic [31:0] o0, o1;
    logic [1:0]  ack, err;
    logic [31:0] min;
  } vec_t;

  vec_t tbl[$];
  int passed = 0;
  int total  = 0;

  function automatic vec_t V(
    input logic rst, rd0, wr0, rd1, wr1, mov, input logic [31:0] mout, input logic mack,
    input logic [15:0] blen, input logic [31:0] in1,
    input logic [1:0] g, input logic mrd, mwr, input logic [31:0] maddr, input logic [1:0] ov,
    input logic [31:0] o0, o1, input logic [1:0] ack, err, input logic [31:0] min);
    vec_t v;
    v.rst = rst; v.rd0 = rd0; v.wr0 = wr0; v.rd1 = rd1; v.wr1 = wr1; v.mov = mov;
    v.mout = mout; v.mack = mack; v.blen = blen; v.in1 = in1;
    v.g = g; v.mrd = mrd; v.mwr = mwr; v.maddr = maddr; v.ov = ov;
    v.o0 = o0; v.o1 = o1; v.ack = ack; v.err = err; v.min = min;
    return v;
  endfunction

  task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic logic [137:0] observe();
    return {bus.req1_grant, bus.req0_grant, bus.mem_rdreq, bus.mem_wrreq, bus.mem_addr,
            bus.req1_out_valid, bus.req0_out_valid, bus.req0_out, bus.req1_out,
            bus.req1_in_ack, bus.req0_in_ack, bus.req1_err, bus.req0_err, bus.mem_in};
  endfunction

  task automatic drive(input vec_t v);
    reset             = v.rst;
    bus.req0_rdreq    = v.rd0;
    bus.req0_wrreq    = v.wr0;
    bus.req1_rdreq    = v.rd1;
    bus.req1_wrreq    = v.wr1;
    bus.mem_out_valid = v.mov;
    bus.mem_out       = v.mout;
    bus.mem_in_ack    = v.mack;
    bus.mem_burstlen  = v.blen;
    bus.req1_in       = v.in1;
  endtask

  initial begin
    int  n;
    bit  found;
    bus.req0_addr = A0;
    bus.req1_addr = A1;
    bus.req0_in   = IN0;
    drive(V(1,0,0,0,0,0,Z,0,0,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    repeat (2) @(posedge clk);

    // Single read burst on port 0, four beats with one gap; stray valids after the burst.
    tbl.push_back(V(1,0,0,0,0,0,Z,0,4,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,1,0,0,0,0,Z,0,4,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,4,Z, 1,1,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'hD000_0000,0,4,Z, 1,0,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'hD000_0001,0,4,Z, 1,0,0,A0,1,32'hD000_0000,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,4,Z, 1,0,0,A0,1,32'hD000_0001,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'hD000_0002,0,4,Z, 1,0,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'hD000_0003,0,4,Z, 1,0,0,A0,1,32'hD000_0002,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'hDEAD_BEEF,0,4,Z, 1,0,0,A0,1,32'hD000_0003,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'hDEAD_BEEF,0,4,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,4,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    // Both ports request after reset: port 0, then port 1, then port 0 again.
    tbl.push_back(V(1,0,0,0,0,0,Z,0,1,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,1,0,1,0,0,Z,0,1,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,1,0,0,Z,0,1,Z, 1,1,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,1,0,1,32'h11,0,1,Z, 1,0,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,1,0,0,Z,0,1,Z, 1,0,0,A0,1,32'h11,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,1,0,0,Z,0,1,32'h5555, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,32'h5555, 2,1,0,A1,0,Z,Z,0,0,32'h5555));
    tbl.push_back(V(0,0,0,0,0,1,32'h22,0,1,32'h5555, 2,0,0,A1,0,Z,Z,0,0,32'h5555));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,32'h5555, 2,0,0,A1,2,Z,32'h22,0,0,32'h5555));
    tbl.push_back(V(0,1,0,1,0,0,Z,0,1,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 1,1,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'h33,0,1,Z, 1,0,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 1,0,0,A0,1,32'h33,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    // Port 1 two-beat write; acks only counted in WRITE, mem_in follows req1_in.
    tbl.push_back(V(0,0,0,0,1,0,Z,0,2,32'h100, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,2,32'h101, 2,0,1,A1,0,Z,Z,0,0,32'h101));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,2,32'h102, 2,0,0,A1,0,Z,Z,0,0,32'h102));
    tbl.push_back(V(0,0,0,0,0,0,Z,1,2,32'h103, 2,0,0,A1,0,Z,Z,2,0,32'h103));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,2,32'h104, 2,0,0,A1,0,Z,Z,0,0,32'h104));
    tbl.push_back(V(0,0,0,0,0,0,Z,1,2,32'h105, 2,0,0,A1,0,Z,Z,2,0,32'h105));
    tbl.push_back(V(0,0,0,0,0,0,Z,1,2,32'h106, 2,0,0,A1,0,Z,Z,0,0,32'h106));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,2,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    // Port 0 rd+wr together with burstlen 0: one-beat write, then the pending read.
    tbl.push_back(V(0,1,1,0,0,0,Z,0,0,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,1,0,0,0,0,Z,0,0,Z, 1,0,1,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,1,0,0,0,0,Z,1,0,Z, 1,0,0,A0,0,Z,Z,1,0,IN0));
    tbl.push_back(V(0,1,0,0,0,0,Z,0,1,Z, 1,0,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,1,0,0,0,0,Z,0,1,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 1,1,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'h44,0,1,Z, 1,0,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 1,0,0,A0,1,32'h44,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    // Reset in the middle of an 8-beat read; pointer must come back to port 0.
    tbl.push_back(V(0,1,0,0,0,0,Z,0,8,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,8,Z, 1,1,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'h51,0,8,Z, 1,0,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'h52,0,8,Z, 1,0,0,A0,1,32'h51,Z,0,0,IN0));
    tbl.push_back(V(1,0,0,0,0,1,32'h53,0,8,Z, 1,0,0,A0,1,32'h52,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'h54,0,8,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,1,0,1,0,0,Z,0,1,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 1,1,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,1,32'h66,0,1,Z, 1,0,0,A0,0,Z,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 1,0,0,A0,1,32'h66,Z,0,0,IN0));
    tbl.push_back(V(0,0,0,0,0,0,Z,0,1,Z, 0,0,0,Z,0,Z,Z,0,0,Z));

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      @(posedge clk); #1;
      drive(v);
      #4;
      chk($sformatf("vec%0d", i), observe(),
          {v.g, v.mrd, v.mwr, v.maddr, v.ov, v.o0, v.o1, v.ack, v.err, v.min});
    end

    // Watchdog: port 0 read with no data, err expected on the 1024th READ cycle.
    @(posedge clk); #1;
    drive(V(0,1,0,0,0,0,Z,0,4,Z, 0,0,0,Z,0,Z,Z,0,0,Z));
    @(posedge clk); #1;
    bus.req0_rdreq = 1'b0;
    #4;
    chk1("wd_grant_strobe", bus.mem_rdreq & bus.req0_grant, 1'b1);
    n = 0;
    found = 1'b0;
    for (int k = 1; k <= 1100 && !found; k++) begin
      @(posedge clk); #5;
      n = k;
      if (bus.req0_err | bus.req1_err) found = 1'b1;
    end
    chk("wd_err_cycle", 138'(found ? n : -1), 138'(1024));
    chk1("wd_err_owner_only", bus.req1_err, 1'b0);
    @(posedge clk); #5;
    chk1("wd_err_one_pulse", bus.req0_err, 1'b0);
    chk1("wd_release_grant", bus.req0_grant, 1'b1);
    @(posedge clk); #5;
    chk1("wd_idle_grant", bus.req0_grant, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
